wb_switch_poller: RTL
=====================

WB_SWITCH_POLLER -- requirements
Module: wb_switch_poller

Interface
REQ-001 SHALL have parameter POLL_DIV, default 1000: clock cycles between poll starts (legal 4..2^20).
REQ-002 SHALL have parameter RD_ADR, default 32'h0: address of the 8-bit switch register read.
REQ-003 SHALL have parameter WR_ADR, default 32'h4: address of the 8-bit output register written.
REQ-004 SHALL have parameter TIMEOUT, default 15: maximum wait cycles for a termination per access.
REQ-005 wb_clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 wb_rst_n  in  1  asynchronous, active-low reset.
REQ-007 wb_adr_o  out  32  Wishbone address.
REQ-008 wb_dat_o  out  8  write data.
REQ-009 wb_dat_i  in  8  read data.
REQ-010 wb_we_o  out  1  write enable.
REQ-011 wb_cyc_o, wb_stb_o  out  1 each  cycle and strobe, always asserted together.
REQ-012 wb_cti_o  out  3  constant 3'b000; wb_bte_o  out  2  constant 2'b00.
REQ-013 wb_ack_i, wb_err_i, wb_rty_i  in  1 each  cycle terminations.
REQ-014 enable_i  in  1  polling enable.
REQ-015 value_o  out  8  last value successfully written to WR_ADR.
REQ-016 change_o  out  1  one-cycle pulse on each successful write.
REQ-017 error_o  out  1  one-cycle pulse on err, rty or timeout.

Function
REQ-018 All outputs SHALL be registered.
REQ-019 Poll timer SHALL count 0..POLL_DIV-1 while enable_i=1, wrap to 0, and hold at 0 while enable_i=0.
REQ-020 Timer wrap in IDLE SHALL assert cyc/stb the next cycle (RD state) with we_o=0 and adr_o=RD_ADR.
REQ-021 A timer wrap outside IDLE SHALL be discarded, not queued.
REQ-022 States: IDLE, RD, CMP, WR; cyc/stb SHALL be high only in RD and WR.
REQ-023 RD: on ack_i, wb_dat_i SHALL be captured and the FSM SHALL move to CMP with cyc/stb low the following cycle.
REQ-024 CMP (1 cycle): if no value has been written since reset, or the captured value differs from value_o, the FSM SHALL go to WR; otherwise to IDLE.
REQ-025 WR: adr_o=WR_ADR, we_o=1, dat_o=captured value, held stable until termination.
REQ-026 WR ack_i SHALL update value_o and pulse change_o in the same cycle as the IDLE entry.
REQ-027 err_i or rty_i in RD or WR SHALL drop cyc/stb the next cycle, pulse error_o, and return to IDLE without retry.
REQ-028 value_o SHALL NOT change on a failed write, so the next poll retries it.
REQ-029 If no termination arrives within TIMEOUT cycles of stb assertion, the FSM SHALL apply REQ-027.
REQ-030 Simultaneous ack_i and err_i SHALL be treated as err.
REQ-031 Terminations arriving in IDLE or CMP SHALL be ignored.
REQ-032 Deasserting enable_i mid-access SHALL let the current RD/CMP/WR sequence finish.

Reset
REQ-033 wb_rst_n=0 SHALL immediately set the following:
- FSM to IDLE and timer to 0.
- cyc_o, stb_o, we_o, change_o and error_o to 0.
- adr_o, dat_o and value_o to 0.
- The "written since reset" flag cleared.
REQ-034 Reset asserted during an access SHALL drop cyc/stb asynchronously.
REQ-035 After release, the first poll SHALL occur POLL_DIV cycles after enable_i is high.

Verification
REQ-036 POLL_DIV=8, slave acks in 1 cycle with 8'hA5 -> read at RD_ADR, then write 8'hA5 to WR_ADR, change_o pulse, value_o=8'hA5.
REQ-037 Switch stays 8'hA5 on the next poll -> read only, no write, no change_o.
REQ-038 Write answered with err_i -> error_o pulse, value_o unchanged; the next poll rewrites the value.
REQ-039 Slave never acks, TIMEOUT=15 -> cyc drops after 15 cycles and error_o pulses; the FSM polls again at the next wrap.
REQ-040 Slave stalls longer than POLL_DIV -> only one access is issued and the extra wrap is dropped.
REQ-041 wb_rst_n pulsed low mid-WR -> cyc_o=0 at once, value_o=0, and the next poll writes even an unchanged value.

Source files
------------

// File: rtl/wb_switch_poller.sv
// wb_switch_poller: periodically reads an 8-bit switch register over Wishbone and writes it to an output register on change.
module wb_switch_poller #(
  parameter int          POLL_DIV = 1000,
  parameter logic [31:0] RD_ADR   = 32'h0,
  parameter logic [31:0] WR_ADR   = 32'h4,
  parameter int          TIMEOUT  = 15
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  output logic [31:0] wb_adr_o,
  output logic [7:0]  wb_dat_o,
  input  logic [7:0]  wb_dat_i,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [2:0]  wb_cti_o,
  output logic [1:0]  wb_bte_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i,
  input  logic        enable_i,
  output logic [7:0]  value_o,
  output logic        change_o,
  output logic        error_o
);
  typedef enum logic [1:0] {IDLE, RD, CMP, WR} state_t;
  state_t      state, state_d;
  logic [20:0] timer;
  logic [15:0] wcnt;
  logic [7:0]  cap;
  logic        written, wrap, busy, bad, ok;
  assign wb_cti_o = 3'b000;
  assign wb_bte_o = 2'b00;
  // an ack on the last allowed wait cycle still counts; err/rty always win over ack
  always_comb begin
    wrap    = enable_i && timer == 21'(POLL_DIV - 1);
    busy    = state == RD || state == WR;
    bad     = busy && (wb_err_i || wb_rty_i || (!wb_ack_i && wcnt == 16'(TIMEOUT - 1)));
    ok      = busy && wb_ack_i && !bad;
    state_d = bad ? IDLE :
              state == IDLE ? (wrap ? RD : IDLE) :
              state == RD   ? (ok ? CMP : RD) :
              state == CMP  ? ((!written || cap != value_o) ? WR : IDLE) :
                              (ok ? IDLE : WR);
  end
  always_ff @(posedge wb_clk or negedge wb_rst_n)
    if (!wb_rst_n) begin
      state    <= IDLE;
      timer    <= '0;
      wcnt     <= '0;
      cap      <= '0;
      written  <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_we_o  <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      value_o  <= '0;
      change_o <= 1'b0;
      error_o  <= 1'b0;
    end else begin
      state    <= state_d;
      timer    <= (!enable_i || wrap) ? '0 : timer + 21'd1;
      wcnt     <= (busy && state_d == state) ? wcnt + 16'd1 : '0;
      wb_cyc_o <= state_d == RD || state_d == WR;
      wb_stb_o <= state_d == RD || state_d == WR;
      wb_we_o  <= state_d == WR;
      if (state == IDLE && state_d == RD) wb_adr_o <= RD_ADR;
      if (state == CMP && state_d == WR) begin
        wb_adr_o <= WR_ADR;
        wb_dat_o <= cap;
      end
      if (state == RD && ok) cap <= wb_dat_i;
      if (state == WR && ok) begin
        value_o <= wb_dat_o;
        written <= 1'b1;
      end
      change_o <= state == WR && ok;
      error_o  <= bad;
    end
endmodule
